// File: rtl/fixed_pkg.sv
// Shared fixed-point types, FSM state encoding and a saturating adder
// for the vector normalizer datapath.
package fixed_pkg;

    localparam int FX_WIDTH = 32;
    localparam int FX_FBITS = 16;

    typedef logic signed [FX_WIDTH-1:0] fx_t;

    typedef enum logic [2:0] {
        VN_IDLE,
        VN_SQ,
        VN_ISQ_START,
        VN_ISQ_WAIT,
        VN_MUL,
        VN_DONE
    } vn_state_t;

    // Unsigned add clamped to a w-bit all-ones ceiling; both operands arrive zero-extended.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        s     = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[63:0];
    endfunction

endpackage

// File: rtl/vec3_normalize_inv_sqrt.sv
// Iterative reciprocal square root: root = floor(2^(3*FBITS/2) / sqrt(rad)),
// found one result bit per cycle from the MSB down. Restarts on every start pulse.
module inv_sqrt #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16
) (
    input  logic             clk,
    input  logic             start,
    input  logic [WIDTH-1:0] rad,
    output logic             valid,
    output logic [WIDTH-1:0] root
);

    localparam int PW = 3 * WIDTH;
    localparam logic [PW-1:0] LIMIT = {{(PW-1){1'b0}}, 1'b1} << (3 * FBITS);

    logic [WIDTH-1:0]   rad_q;
    logic [WIDTH-1:0]   root_q;
    logic [WIDTH-1:0]   bit_q;
    logic               busy_q;
    logic               valid_q;
    logic [WIDTH-1:0]   trial;
    logic [2*WIDTH-1:0] trial_sq;
    logic [PW-1:0]      prod;
    logic               fits;

    // Keep the trial bit when trial^2 * rad still fits under 2^(3*FBITS).
    always_comb begin
        trial    = root_q | bit_q;
        trial_sq = {{WIDTH{1'b0}}, trial} * {{WIDTH{1'b0}}, trial};
        prod     = {{WIDTH{1'b0}}, trial_sq} * {{(2*WIDTH){1'b0}}, rad_q};
        fits     = (prod <= LIMIT);
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rad_q   <= rad;
            root_q  <= '0;
            bit_q   <= {1'b1, {(WIDTH-1){1'b0}}};
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else if (busy_q) begin
            if (fits) root_q <= trial;
            bit_q <= bit_q >> 1;
            if (bit_q[0]) begin
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign root  = root_q;

endmodule

// File: rtl/vec3_normalize.sv
// Fixed-point 3-vector normalizer: sums squared components, asks inv_sqrt for
// 1/|v| and scales each component, all on one shared signed multiplier.
module vec3_normalize
    import fixed_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int FBITS = FX_FBITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z,
    output logic                    out_zero
);

    typedef logic signed [WIDTH-1:0]   comp_t;
    typedef logic signed [2*WIDTH-1:0] wide_t;

    vn_state_t        state_q;
    comp_t            x_q, y_q, z_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] root_q;
    logic [1:0]       idx_q;
    logic             start_q;
    logic             in_ready_q, out_valid_q, out_zero_q;
    comp_t            out_x_q, out_y_q, out_z_q;

    comp_t            op_a, op_b, scaled;
    wide_t            mul_p;

    logic             isq_start;
    logic [WIDTH-1:0] isq_rad;
    logic             isq_valid;
    logic [WIDTH-1:0] isq_root;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        case (idx_q)
            2'd1:    op_a = y_q;
            2'd2:    op_a = z_q;
            default: op_a = x_q;
        endcase
        op_b   = (state_q == VN_SQ) ? op_a : $signed(root_q);
        mul_p  = wide_t'(op_a) * wide_t'(op_b);
        acc_d  = WIDTH'(sat_add(64'(acc_q), 64'(mul_p[2*WIDTH-1:FBITS]), WIDTH));
        scaled = WIDTH'(mul_p >>> FBITS);
    end

    // NOTE: operand, accumulator and root registers carry no reset; they are always
    // written before use, and only control/output state must return to a known value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= VN_IDLE;
            idx_q       <= 2'd0;
            start_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
        end else begin
            case (state_q)
                VN_IDLE: begin
                    if (in_valid) begin
                        x_q        <= in_x;
                        y_q        <= in_y;
                        z_q        <= in_z;
                        acc_q      <= '0;
                        idx_q      <= 2'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= VN_SQ;
                    end
                end
                VN_SQ: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd2) begin
                        idx_q <= 2'd0;
                        if (acc_d == '0) begin
                            out_x_q     <= '0;
                            out_y_q     <= '0;
                            out_z_q     <= '0;
                            out_zero_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= VN_DONE;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= VN_ISQ_START;
                        end
                    end
                end
                VN_ISQ_START: begin
                    start_q <= 1'b0;
                    state_q <= VN_ISQ_WAIT;
                end
                VN_ISQ_WAIT: begin
                    // Results of a start abandoned by reset never reach here: a fresh start precedes this wait.
                    if (isq_valid) begin
                        root_q  <= isq_root;
                        idx_q   <= 2'd0;
                        state_q <= VN_MUL;
                    end
                end
                VN_MUL: begin
                    case (idx_q)
                        2'd0:    out_x_q <= scaled;
                        2'd1:    out_y_q <= scaled;
                        default: out_z_q <= scaled;
                    endcase
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd2) begin
                        idx_q       <= 2'd0;
                        out_zero_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= VN_DONE;
                    end
                end
                VN_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= VN_IDLE;
                    end
                end
                default: state_q <= VN_IDLE;
            endcase
        end
    end

    assign isq_start = start_q;
    assign isq_rad   = acc_q;

    inv_sqrt #(
        .WIDTH(WIDTH),
        .FBITS(FBITS)
    ) u_inv_sqrt (
        .clk  (clk),
        .start(isq_start),
        .rad  (isq_rad),
        .valid(isq_valid),
        .root (isq_root)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_vec3_normalize.sv
// Directed bench for vec3_normalize with hand-computed Q16.16 results and
// cycle-accurate handshake timing.
module tb_vec3_normalize;
    import fixed_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    fx_t  in_x, in_y, in_z;
    logic in_ready, out_valid, out_zero;
    fx_t  out_x, out_y, out_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec3_normalize #(.WIDTH(32), .FBITS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_z     (in_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_z    (out_z),
        .out_zero (out_zero)
    );

    task automatic check(input string tag, input longint got, input longint exp,
                         input longint tol = 0);
        longint d;
        checks++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) tol %0d",
                     tag, got, got, exp, exp, tol);
        end
    endtask

    // Submit one vector and wait (bounded) for out_valid; cycle 0 is the input handshake.
    task automatic run_vec(input string tag, input fx_t x, input fx_t y, input fx_t z,
                           output int out_cyc, output int start_cyc, output int valid_cyc,
                           output logic [31:0] rad_seen);
        int cyc;
        @(negedge clk);
        in_x     = x;
        in_y     = y;
        in_z     = z;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        cyc       = 1;
        out_cyc   = -1;
        start_cyc = -1;
        valid_cyc = -1;
        rad_seen  = '0;
        check({tag, "_busy"}, longint'(in_ready), 0);
        while (cyc < 200) begin
            if (dut.isq_start) begin
                start_cyc = cyc;
                rad_seen  = dut.isq_rad;
            end
            if (dut.isq_valid && start_cyc >= 0 && valid_cyc < 0) valid_cyc = cyc;
            if (out_valid) begin
                out_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_done"}, longint'(out_valid), 1);
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ovalid_clr"}, longint'(out_valid), 0);
        check({tag, "_iready_set"}, longint'(in_ready), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, longint'(in_ready), 1);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_out_x"}, longint'(out_x), 0);
        check({tag, "_out_y"}, longint'(out_y), 0);
        check({tag, "_out_z"}, longint'(out_z), 0);
        check({tag, "_out_zero"}, longint'(out_zero), 0);
        check({tag, "_start"}, longint'(dut.isq_start), 0);
    endtask

    initial begin
        int          oc, sc, vc;
        logic [31:0] rad;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst = 1'b0;

        // Unit axis: rad = 1.0, root = 1.0
        run_vec("unit", 32'h0001_0000, 0, 0, oc, sc, vc, rad);
        check("unit_start_cyc", sc, 4);
        check("unit_out_cyc", oc, vc + 4);
        check("unit_rad", longint'(rad), 'h10000);
        check("unit_x", longint'(out_x), 65536, 4);
        check("unit_y", longint'(out_y), 0, 4);
        check("unit_z", longint'(out_z), 0, 4);
        check("unit_zero", longint'(out_zero), 0);
        accept("unit");

        // 3-4-0: rad = 25.0, root = 0x3333, out = 0.6, 0.8
        run_vec("tri", 32'h0003_0000, 32'h0004_0000, 0, oc, sc, vc, rad);
        check("tri_rad", longint'(rad), 'h190000);
        check("tri_x", longint'(out_x), 39321, 8);
        check("tri_y", longint'(out_y), 52428, 8);
        check("tri_z", longint'(out_z), 0, 8);
        accept("tri");

        run_vec("neg", -32'sh0003_0000, -32'sh0004_0000, 0, oc, sc, vc, rad);
        check("neg_x", longint'(out_x), -39321, 8);
        check("neg_y", longint'(out_y), -52428, 8);
        check("neg_z", longint'(out_z), 0, 8);
        accept("neg");

        // Zero vector, with out_ready already high before out_valid
        out_ready = 1'b1;
        run_vec("zero", 0, 0, 0, oc, sc, vc, rad);
        check("zero_out_cyc", oc, 4);
        check("zero_no_start", sc, -1);
        check("zero_flag", longint'(out_zero), 1);
        check("zero_x", longint'(out_x), 0);
        check("zero_y", longint'(out_y), 0);
        check("zero_z", longint'(out_z), 0);
        accept("zero");

        // Saturation: rad clamps to all-ones, root = 256, out = 200*256 = 0xC800
        run_vec("sat", 32'h00C8_0000, 32'h00C8_0000, 32'h00C8_0000, oc, sc, vc, rad);
        check("sat_rad", longint'(rad), 64'hFFFF_FFFF);
        check("sat_x", longint'(out_x), 51200, 8);
        check("sat_y", longint'(out_y), 51200, 8);
        check("sat_z", longint'(out_z), 51200, 8);
        accept("sat");

        // Backpressure: outputs frozen while out_ready stays low
        run_vec("bp", 32'h0001_0000, 0, 0, oc, sc, vc, rad);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", longint'(out_valid), 1);
            check("bp_in_ready", longint'(in_ready), 0);
            check("bp_x", longint'(out_x), 65536, 4);
            check("bp_y", longint'(out_y), 0, 4);
        end
        accept("bp");

        // Reset while waiting on inv_sqrt, then an unrelated vector
        @(negedge clk);
        in_x     = 32'h0003_0000;
        in_y     = 32'h0004_0000;
        in_z     = 0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 50 && !dut.isq_start; i++) begin
            @(posedge clk);
            #1;
        end
        check("mid_start_seen", longint'(dut.isq_start), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        rst = 1'b0;

        // rad = 4.0, root = 0.5, out_y = 1.0
        run_vec("after", 0, 32'h0002_0000, 0, oc, sc, vc, rad);
        check("after_rad", longint'(rad), 'h40000);
        check("after_x", longint'(out_x), 0, 4);
        check("after_y", longint'(out_y), 65536, 4);
        check("after_z", longint'(out_z), 0, 4);
        check("after_zero", longint'(out_zero), 0);
        accept("after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec3_normalize.md
# vec3_normalize

Fixed-point 3-vector normalizer. Accepts a signed Q(WIDTH-FBITS).FBITS vector (x, y, z), forms the squared magnitude, drives the team's iterative `inv_sqrt` core as its initiator (start/rad out, valid/root back), and scales each component by the returned 1/|v|. It sits between the vector-producing datapath and any consumer that needs unit vectors, such as shading or direction normalization.

## Interface
- WIDTH, 32, total bits of every fixed-point value
- FBITS, 16, fractional bits
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input vector present
- in_ready  out  1  block idle, can accept a vector
- in_x, in_y, in_z  in  WIDTH  signed components
- out_valid  out  1  result present; held until accepted
- out_ready  in  1  consumer accepts result
- out_x, out_y, out_z  out  WIDTH  signed normalized components
- out_zero  out  1  input was the zero vector (or its magnitude underflowed to zero)

## Operation
- States: IDLE, SQ, ISQ_START, ISQ_WAIT, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch x/y/z, clear the accumulator, go to SQ.
- SQ:
  - Takes 3 cycles on one shared WIDTH×WIDTH signed multiplier.
  - Each cycle adds (c*c)>>FBITS, treated as unsigned, to an unsigned WIDTH-bit accumulator.
  - On overflow the accumulator saturates to all-ones and stays saturated.
- Exit from SQ:
  - If the sum is 0: out_x/y/z=0, out_zero=1, go to DONE. inv_sqrt is not started.
  - Otherwise go to ISQ_START.
- ISQ_START:
  - Drive start=1 and rad=sum to inv_sqrt for exactly one cycle.
  - Go to ISQ_WAIT.
- ISQ_WAIT:
  - Hold start=0 and wait for valid.
  - Latch root in the cycle valid=1, then go to MUL.
- MUL:
  - Takes 3 cycles on the same multiplier.
  - out_c = (c*root)>>>FBITS, an arithmetic shift (floor), truncated to WIDTH.
  - out_zero=0.
- DONE:
  - out_valid=1 and all outputs are held stable.
  - Return to IDLE in the cycle out_ready=1.
- inv_sqrt contract:
  - A start pulse restarts the core unconditionally.
  - valid refers to the most recent start.
  - Latency L is variable, at least 1.
  - The core has no reset.
- Reset:
  - Any state returns to IDLE; latched operands are discarded.
  - An inv_sqrt computation still in flight is ignored, because valid is only sampled in ISQ_WAIT and the next ISQ_START restarts the core.

## Timing
- Reset values: in_ready=1, out_valid=0, out_x/y/z=0, out_zero=0. Internal: start=0, state IDLE.
- Let cycle 0 be the in_valid&&in_ready handshake.
- SQ occupies cycles 1–3.
- Zero vector: out_valid rises at cycle 4.
- Non-zero vector:
  - start is high at cycle 4.
  - inv_sqrt valid arrives at cycle 4+L.
  - MUL occupies cycles 5+L to 7+L.
  - out_valid rises at cycle 8+L.
- in_ready=0 from cycle 1 until the cycle after the out handshake. There is no overlap between vectors.
- out_valid with out_ready=0: outputs are frozen indefinitely.
- out_ready high while out_valid=0 is ignored.
- Simultaneous rst and any handshake: rst wins.

## Structure
- Shared package `fixed_pkg`:
  - WIDTH/FBITS defaults.
  - typedef `fx_t` (logic signed [WIDTH-1:0]).
  - State enum `vn_state_t`.
  - Saturating-add helper function.
- Sub-module: one instance of the existing `inv_sqrt` (WIDTH, FBITS passed through).
- The multiplier is inline, with a 3-way operand mux. No separate module.

## Test plan
- Unit axis:
  - Stimulus: (0x00010000, 0, 0).
  - Required: out = (0x00010000, 0, 0) ±4 LSB, out_zero=0.
- 3-4-0 triangle:
  - Stimulus: (0x00030000, 0x00040000, 0).
  - Required: rad=0x00190000; out ≈ (0x00009999, 0x0000CCCC, 0) ±8 LSB.
  - Also check: negated inputs give negated outputs.
- Zero vector:
  - Stimulus: (0, 0, 0).
  - Required: out_valid at cycle 4, out_zero=1, all outputs 0.
  - Also check: inv_sqrt start never asserted.
- Saturation:
  - Stimulus: (0x00C80000, 0x00C80000, 0x00C80000), i.e. 200,200,200.
  - Required: rad=0xFFFFFFFF; output finite, same sign on all components, no wrap.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
  - Required: outputs stable, in_ready=0, then a single handshake returns to IDLE.
- Reset mid-operation:
  - Stimulus: assert rst during ISQ_WAIT, then submit (0, 0x00020000, 0).
  - Required: all outputs at their reset values; the new result is (0, 0x00010000, 0) ±4 LSB, unaffected by the stale inv_sqrt result.
